// File: rtl/rotate_tile_buf_if.sv
// Pixel stream bundle for rotate_tile_buf: raster input (s_*) and rotated output (m_*).
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface rotate_tile_buf_if #(
    parameter int PIX_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/rotate_tile_buf.sv
// Ping-pong T x T tile buffer that re-emits each tile rotated by 0/90/180/270 degrees.
// Define ROTATE_TILE_BUF_OUT_REG_EN to add an output register after the skid (one extra cycle latency).
module rotate_tile_buf #(
    parameter int PIX_W     = 16,
    parameter int TILE_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       rot_mode,
    rotate_tile_buf_if.slave bus,
    output logic             idle
);
    localparam int            AW       = 2 * TILE_LOG2;
    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    logic [1:0]           bank_st  [2];
    logic [1:0]           bank_nxt [2];
    logic [1:0]           mode_q   [2];
    logic                 wb, wb_nxt, rb, ob;
    logic [AW-1:0]        wc, rc;
    logic                 s_ready_q, s_ready_nxt;
    logic                 wr_fire, rd_fire, rd_room;
    logic                 rd_vld, rd_last;
    logic [PIX_W-1:0]     rd_data;
    logic [PIX_W-1:0]     mem [2**(AW+1)];
    logic [TILE_LOG2-1:0] row, col, src_row, src_col;
    logic [AW:0]          rd_addr;
    logic [2:0]           occ;

    logic [PIX_W-1:0]     sk_data [2];
    logic                 sk_last [2];
    logic                 sk_wp, sk_rp, sk_pop;
    logic [1:0]           sk_cnt;
    logic                 out_valid, out_last, out_fire, pipe_busy;

    assign wr_fire     = bus.s_valid && s_ready_q;
    assign bus.s_ready = s_ready_q;
    assign out_fire    = out_valid && bus.m_ready;

    // Reads may issue as long as the skid cannot overflow once in-flight data lands.
    assign occ     = {1'b0, sk_cnt} + {2'b00, rd_vld} - {2'b00, sk_pop};
    assign rd_room = occ < 3'd2;
    assign rd_fire = rd_room && ((bank_st[rb] == ST_FULL) ||
                                 (bank_st[rb] == ST_DRAINING && rc != '0));

    assign row = rc[AW-1:TILE_LOG2];
    assign col = rc[TILE_LOG2-1:0];

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can infer a latch.
        src_row = row;
        src_col = col;
        case (mode_q[rb])
            2'd1:    begin src_row = ~col; src_col = row;  end
            2'd2:    begin src_row = ~row; src_col = ~col; end
            2'd3:    begin src_row = col;  src_col = ~row; end
            default: begin src_row = row;  src_col = col;  end
        endcase
    end

    assign rd_addr = {rb, src_row, src_col};

    // Writer, reader and drain-end touch banks in distinct states, so all three apply together.
    always_comb begin
        bank_nxt = bank_st;
        wb_nxt   = wb;
        if (wr_fire) begin
            if (wc == LAST_IDX) begin
                bank_nxt[wb] = ST_FULL;
                wb_nxt       = ~wb;
            end else begin
                bank_nxt[wb] = ST_FILLING;
            end
        end
        if (rd_fire && bank_st[rb] == ST_FULL)
            bank_nxt[rb] = ST_DRAINING;
        if (out_fire && out_last)
            bank_nxt[ob] = ST_EMPTY;
        s_ready_nxt = (bank_nxt[wb_nxt] == ST_EMPTY) || (bank_nxt[wb_nxt] == ST_FILLING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_st   <= '{ST_EMPTY, ST_EMPTY};
            mode_q    <= '{2'd0, 2'd0};
            wb        <= 1'b0;
            rb        <= 1'b0;
            ob        <= 1'b0;
            wc        <= '0;
            rc        <= '0;
            s_ready_q <= 1'b0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            bank_st   <= bank_nxt;
            wb        <= wb_nxt;
            s_ready_q <= s_ready_nxt;
            if (wr_fire) begin
                wc <= wc + AW'(1);
                if (wc == '0)
                    mode_q[wb] <= rot_mode;
            end
            if (rd_fire) begin
                rc <= rc + AW'(1);
                if (rc == LAST_IDX)
                    rb <= ~rb;
            end
            rd_vld  <= rd_fire;
            rd_last <= rd_fire && (rc == LAST_IDX);
            if (out_fire && out_last)
                ob <= ~ob;
        end
    end

    // NOTE: the pixel RAM is not reset; bank state guarantees stale words are never read out.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{wb, wc}] <= bus.s_data;
        if (rd_fire)
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sk_data <= '{default: '0};
            sk_last <= '{default: 1'b0};
            sk_wp   <= 1'b0;
            sk_rp   <= 1'b0;
            sk_cnt  <= 2'd0;
        end else begin
            if (rd_vld) begin
                sk_data[sk_wp] <= rd_data;
                sk_last[sk_wp] <= rd_last;
                sk_wp          <= ~sk_wp;
            end
            if (sk_pop)
                sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt + {1'b0, rd_vld} - {1'b0, sk_pop};
        end
    end

`ifdef ROTATE_TILE_BUF_OUT_REG_EN
    logic             o_valid, o_last;
    logic [PIX_W-1:0] o_data;

    assign sk_pop = (sk_cnt != 2'd0) && (!o_valid || bus.m_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else if (sk_pop) begin
            o_valid <= 1'b1;
            o_data  <= sk_data[sk_rp];
            o_last  <= sk_last[sk_rp];
        end else if (bus.m_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign out_valid  = o_valid;
    assign out_last   = o_last && o_valid;
    assign bus.m_data = o_data;
    assign pipe_busy  = o_valid;
`else
    assign sk_pop     = (sk_cnt != 2'd0) && bus.m_ready;
    assign out_valid  = sk_cnt != 2'd0;
    assign out_last   = sk_last[sk_rp] && out_valid;
    assign bus.m_data = sk_data[sk_rp];
    assign pipe_busy  = 1'b0;
`endif

    assign bus.m_valid = out_valid;
    assign bus.m_last  = out_last;

    assign idle = (bank_st[0] == ST_EMPTY) && (bank_st[1] == ST_EMPTY) &&
                  !rd_vld && (sk_cnt == 2'd0) && !pipe_busy;
endmodule

// File: tb/tb_rotate_tile_buf.sv
// Directed bench for rotate_tile_buf with T=4, PIX_W=16: rotation modes, back-to-back tiles,
// output back-pressure and mid-tile reset.
module tb_rotate_tile_buf;
    localparam int PIX_W     = 16;
    localparam int TILE_LOG2 = 2;
`ifdef ROTATE_TILE_BUF_OUT_REG_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif

    // Hand-derived output order (input index per output position) for each rotation mode.
    localparam int EXP_TAB [4][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{12,  8,  4,  0, 13,  9,  5,  1, 14, 10,  6,  2, 15, 11,  7,  3},
        '{15, 14, 13, 12, 11, 10,  9,  8,  7,  6,  5,  4,  3,  2,  1,  0},
        '{ 3,  7, 11, 15,  2,  6, 10, 14,  1,  5,  9, 13,  0,  4,  8, 12}
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rot_mode;
    logic       idle;

    rotate_tile_buf_if #(.PIX_W(PIX_W)) bus ();

    rotate_tile_buf #(.PIX_W(PIX_W), .TILE_LOG2(TILE_LOG2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rot_mode (rot_mode),
        .bus      (bus),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks   = 0;
    int         failures = 0;
    int         cur_base;
    logic [1:0] cur_mode [3];
    logic       scramble;
    logic       toggle_ready;
    int         last_hs_cyc;
    int         first_valid_cyc;

    task automatic drive(input int n);
        int   k      = 0;
        int   budget = 0;
        int   lows   = 0;
        logic acc;
        while (k < n && budget < 600) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(cur_base + k);
            if (!scramble || (k % 16 == 0))
                rot_mode = cur_mode[k / 16];
            else
                rot_mode = 2'(cur_mode[k / 16] + 1 + k % 3);
            acc = bus.s_ready;
            if (scramble && !acc) begin
                lows++;
                checks++;
                if (k != 32) begin
                    failures++;
                    $display("FAIL b2b_s_ready_low pending_pixel=%0d required=32", k);
                end
            end
            if (acc && k == n - 1)
                last_hs_cyc = cyc + 1;
            @(negedge clk);
            budget++;
            if (acc)
                k++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", k, n);
        end
        if (scramble) begin
            checks++;
            if (lows == 0) begin
                failures++;
                $display("FAIL b2b_s_ready_stall low_cycles=%0d required=nonzero", lows);
            end
        end
    endtask

    task automatic collect(input int n, input string name);
        int          got     = 0;
        int          budget  = 0;
        logic        tog     = 1'b1;
        logic        stalled = 1'b0;
        logic        seen    = 1'b0;
        logic [15:0] hold_d  = '0;
        logic        hold_l  = 1'b0;
        int          exp_d;
        logic        exp_l;
        while (got < n && budget < 600) begin
            if (stalled) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== hold_d || bus.m_last !== hold_l) begin
                    failures++;
                    $display("FAIL %s_stall_hold valid=%b data=%0d last=%b required 1/%0d/%b",
                             name, bus.m_valid, bus.m_data, bus.m_last, hold_d, hold_l);
                end
            end
            bus.m_ready = toggle_ready ? tog : 1'b1;
            tog = ~tog;
            if (bus.m_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                first_valid_cyc = cyc;
            end
            if (bus.m_valid === 1'b1 && bus.m_ready) begin
                exp_d = cur_base + 16 * (got / 16) + EXP_TAB[cur_mode[got / 16]][got % 16];
                exp_l = (got % 16 == 15);
                checks++;
                if (bus.m_data !== 16'(exp_d)) begin
                    failures++;
                    $display("FAIL %s_data[%0d] got=%0d required=%0d", name, got, bus.m_data, exp_d);
                end
                checks++;
                if (bus.m_last !== exp_l) begin
                    failures++;
                    $display("FAIL %s_last[%0d] got=%b required=%b", name, got, bus.m_last, exp_l);
                end
                got++;
                stalled = 1'b0;
            end else if (bus.m_valid === 1'b1) begin
                stalled = 1'b1;
                hold_d  = bus.m_data;
                hold_l  = bus.m_last;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        bus.m_ready = 1'b0;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s_timeout outputs=%0d required=%0d", name, got, n);
        end
    endtask

    task automatic check_quiet(input string name);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.m_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_extra_output m_valid=%b required=0 data=%0d", name, bus.m_valid, bus.m_data);
            end
        end
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle got=%b required=1", name, idle);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        rot_mode     = 2'd0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
            bus.m_data !== 16'd0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_values s_ready=%b m_valid=%b m_last=%b m_data=%0d idle=%b required 0/0/0/0/1",
                     bus.s_ready, bus.m_valid, bus.m_last, bus.m_data, idle);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready_rise got=%b required=1", bus.s_ready);
        end
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            cur_base     = 0;
            cur_mode[0]  = 2'(m);
            scramble     = 1'b0;
            toggle_ready = 1'b0;
            fork
                drive(16);
                collect(16, $sformatf("mode%0d", m));
            join
            if (m == 0) begin
                checks++;
                if (first_valid_cyc - last_hs_cyc != LATENCY) begin
                    failures++;
                    $display("FAIL mode0_latency got=%0d required=%0d", first_valid_cyc - last_hs_cyc, LATENCY);
                end
            end
            check_quiet($sformatf("mode%0d", m));
        end
    endtask

    task automatic test_back_to_back();
        cur_base     = 0;
        cur_mode[0]  = 2'd0;
        cur_mode[1]  = 2'd1;
        cur_mode[2]  = 2'd2;
        scramble     = 1'b1;
        toggle_ready = 1'b0;
        fork
            drive(48);
            collect(48, "b2b");
        join
        scramble = 1'b0;
        check_quiet("b2b");
    endtask

    task automatic test_backpressure();
        cur_base     = 0;
        cur_mode[0]  = 2'd0;
        scramble     = 1'b0;
        toggle_ready = 1'b1;
        fork
            drive(16);
            collect(16, "toggle");
        join
        toggle_ready = 1'b0;
        check_quiet("toggle");
    endtask

    task automatic test_mid_reset();
        cur_base     = 0;
        cur_mode[0]  = 2'd0;
        scramble     = 1'b0;
        toggle_ready = 1'b0;
        bus.m_ready  = 1'b1;
        drive(5);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state idle=%b m_valid=%b s_ready=%b required 1/0/0",
                     idle, bus.m_valid, bus.s_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cur_base = 100;
        fork
            drive(16);
            collect(16, "midreset");
        join
        check_quiet("midreset");
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
